// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_STATES cycles, performs the
// word access (lane-masked store or full-word load) and holds the response
// until the requester consumes it.
//
// Parameters:
//   DEPTH_WORDS  memory size in 32-bit words (power of two)
//   WAIT_STATES  idle cycles between acceptance and access (0..15)
//   BASE_ADDR    byte address of word 0
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only when idle)
//   req_we, req_addr,
//   req_wdata, req_be          store flag, byte address, lane-aligned data, lane enables
//   rsp_valid / rsp_ready      response handshake
//   rsp_rdata, rsp_err         loaded word (0 on stores/errors), access rejected
// Optional feature:
//   DMEM_ALIGN_CHECK_EN        when defined, byte enables must match addr[1:0]
//                              (byte, aligned halfword, aligned word or none).

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access operands: with zero wait states the access happens at the
  // acceptance edge, so the live request fields are used instead of the latch.
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [31:0]      acc_off;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_in_range;
  logic             acc_ok;
  logic             acc_err;
  logic             do_access;
  logic             mem_we;
  logic [31:0]      rd_word;

`ifdef DMEM_ALIGN_CHECK_EN
  function automatic logic align_ok(input logic [1:0] a, input logic [3:0] be);
    return (be == 4'b0000) ||
           (be == (4'b0001 << a)) ||
           (!a[0] && (be == (4'b0011 << a))) ||
           ((a == 2'b00) && (be == 4'b1111));
  endfunction
`endif

  always_comb begin
    acc_we       = (state_q == S_IDLE) ? req_we    : we_q;
    acc_addr     = (state_q == S_IDLE) ? req_addr  : addr_q;
    acc_wdata    = (state_q == S_IDLE) ? req_wdata : wdata_q;
    acc_be       = (state_q == S_IDLE) ? req_be    : be_q;
    acc_off      = acc_addr - BASE_ADDR;
    acc_idx      = acc_off[IDX_W+1:2];
    acc_in_range = (acc_addr >= BASE_ADDR) && ((acc_off >> 2) < DEPTH_L);
`ifdef DMEM_ALIGN_CHECK_EN
    acc_ok       = align_ok(acc_addr[1:0], acc_be);
`else
    acc_ok       = 1'b1;
`endif
    acc_err      = !acc_in_range || !acc_ok;
    do_access    = ((state_q == S_IDLE) && req_valid && NO_WAIT) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd0));
    // Reset at the access edge drops the pending store.
    mem_we       = do_access && acc_we && !acc_err && !reset;
    rd_word      = mem[acc_idx];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = NO_WAIT ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Request latch, wait counter and response registers
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if ((state_q == S_IDLE) && req_valid) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
      cnt_d   = WAIT_LOAD;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (do_access) begin
      rdata_d = (acc_err || acc_we) ? 32'd0 : rd_word;
      err_d   = acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Lane-masked write; memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (1 and 4 wait states) driven
// with directed and randomized transactions, checked against a word-array
// reference model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          ws [2] = '{1, 4};
  logic [31:0] mdl [2][DEPTH];
  int          n_vec = 0;
  int          n_bad = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(4), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: word index from byte address, range/alignment legality,
  // lane merge on store, full word on load.
  task automatic model(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic err);
    logic [31:0] idx;
    logic        ok;
    idx = addr >> 2;
    ok  = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    case (be)
      4'b0000:                            ok = 1'b1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = (int'(addr % 4) == $clog2(int'(be)));
      4'b0011:                            ok = (addr % 4 == 0);
      4'b1100:                            ok = (addr % 4 == 2);
      4'b1111:                            ok = (addr % 4 == 0);
      default:                            ok = 1'b0;
    endcase
`endif
    err = (idx >= DEPTH) || !ok;
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = mdl[d][idx];
      end
    end
  endtask

  // One complete transaction with latency, hold and handshake checks.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int bp,
                     input string tag, output logic [31:0] obs_rd, output logic obs_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    bit          seen;
    @(negedge clk);
    chk({tag, "/req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    model(d, we, addr, wdata, be, exp_rd, exp_err);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      rsp_ready[d] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      seen = rsp_valid[d];
    end
    rsp_ready[d] = 1'b0;
    obs_rd = rsp_rdata[d]; obs_err = rsp_err[d];
    chk({tag, "/latency"}, 32'(lat), 32'(ws[d]));
    if (!seen) return;
    chk({tag, "/rdata"}, rsp_rdata[d], exp_rd);
    chk({tag, "/err"}, 32'(rsp_err[d]), 32'(exp_err));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({tag, "/hold_rdata"}, rsp_rdata[d], exp_rd);
      chk({tag, "/hold_err"}, 32'(rsp_err[d]), 32'(exp_err));
      chk({tag, "/hold_ready"}, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk({tag, "/done_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "/done_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          cnt;

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset/req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset/rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset/rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset/rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    @(negedge clk);
    reset[0] = 1'b0; reset[1] = 1'b0;

    // Word store then load
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", rd, er);
    chk("st10/err_const", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, "ld10", rd, er);
    chk("ld10/value", rd, 32'hDEADBEEF);

    // Byte-lane merge
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, "st20a", rd, er);
    txn(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, "st20b", rd, er);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, "ld20", rd, er);
    chk("ld20/merge", rd, 32'h1122AA44);

    // Backpressure
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 5, "bp20", rd, er);

    // Out of range store leaves word 0 untouched
    txn(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, "st00", rd, er);
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 0, "oor", rd, er);
    chk("oor/err_const", 32'(er), 32'd1);
    chk("oor/rdata_const", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, "ld00", rd, er);
    chk("ld00/unchanged", rd, 32'hA5A5A5A5);

    // Alignment
    txn(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, "st40", rd, er);
    txn(0, 1'b1, 32'h41, 32'h0000BEEF, 4'b0011, 0, "st41", rd, er);
    txn(0, 1'b0, 32'h40, 32'h0, 4'hF, 0, "ld40", rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("ld40/align", rd, 32'hCAFEF00D);
`else
    chk("ld40/align", rd, 32'hCAFEBEEF);
`endif

    // Reset during WAIT (4 wait states) drops the store
    txn(1, 1'b1, 32'h30, 32'h5A5A5A5A, 4'hF, 0, "w4st30", rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h30;
    req_wdata[1] = 32'h12345678; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset[1] = 1'b1;
    @(posedge clk); #1;
    reset[1] = 1'b0;
    chk("rstwait/req_ready", 32'(req_ready[1]), 32'd1);
    chk("rstwait/rsp_valid", 32'(rsp_valid[1]), 32'd0);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) cnt++;
    end
    chk("rstwait/no_rsp", 32'(cnt), 32'd0);
    txn(1, 1'b0, 32'h30, 32'h0, 4'hF, 0, "w4ld30", rd, er);
    chk("w4ld30/old", rd, 32'h5A5A5A5A);

    // Reset while a response is pending
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    cnt = 0;
    while (!rsp_valid[0] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("rstresp/pending", 32'(rsp_valid[0]), 32'd1);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    chk("rstresp/rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rstresp/req_ready", 32'(req_ready[0]), 32'd1);
    chk("rstresp/rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rstresp/rsp_err", 32'(rsp_err[0]), 32'd0);

    // Randomized traffic over a prefilled region
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++)
        txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, "fill", rd, er);
      for (int n = 0; n < ((d == 0) ? 300 : 80); n++) begin
        logic [31:0] a;
        case ($urandom_range(0, 9))
          0:       a = 32'h1000 + $urandom_range(0, 32'h0FFF);
          1:       a = $urandom | 32'h8000_0000;
          default: a = $urandom_range(0, 255);
        endcase
        txn(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "rand", rd, er);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core's load/store port: it accepts one word-addressed request at a time (address, write data, byte enables), performs the access after a programmable number of wait states, and returns read data plus an error flag. It sits on the memory side of the datapath's address/write-data/read-data interface. It replaces the zero-latency memory model so the core and its stall logic can be exercised against a slow memory.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words; power of two.
- `WAIT_STATES`, 1: idle cycles between request acceptance and the access, range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, already lane-aligned by the store extender.
- `req_be` in 4: byte-lane enables; bit i selects `wdata[8i+7:8i]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester consumes the response.
- `rsp_rdata` out 32: full word read; the load extender selects the byte or halfword; 0 on stores and errors.
- `rsp_err` out 1: access rejected.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `we`, `addr`, `wdata` and `be`.
  - Go to WAIT if `WAIT_STATES`>0, otherwise perform the access and go to RESP.
- WAIT:
  - A 4-bit counter loads `WAIT_STATES`-1 at acceptance and decrements each cycle.
  - When it reaches 0, perform the access and go to RESP.
- Access:
  - Word index = (addr − `BASE_ADDR`)>>2.
  - Out of range means addr < `BASE_ADDR`, or index ≥ `DEPTH_WORDS`. In that case: `rsp_err`=1, no write, `rsp_rdata`=0.
  - Store: write only the enabled lanes; other lanes are unchanged. `be`=0000 is a legal no-op with `err`=0.
  - Load: `rsp_rdata` = the stored word, with `be` ignored.
- RESP:
  - `rsp_valid`=1, and `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1.
  - On `rsp_ready`, go to IDLE.
  - The next request is not accepted in the same cycle.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset values: `req_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
- Handshake rules:
  - A request is accepted at the edge where `req_valid`&&`req_ready`.
  - Request fields are sampled only at that edge and may change afterwards.
  - The response is transferred at the edge where `rsp_valid`&&`rsp_ready`.
- Latency:
  - With acceptance at edge N, `rsp_valid` rises after edge N+1+`WAIT_STATES`−1 = N+`WAIT_STATES`.
  - `WAIT_STATES`=0 gives `rsp_valid` in the cycle after acceptance.
  - The store commits at the same edge `rsp_valid` rises.
- Throughput: at most one request per `WAIT_STATES`+2 cycles when `rsp_ready` is held high.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- Reset mid-operation:
  - A request in WAIT is dropped and its store is never performed.
  - A response pending in RESP is discarded.
  - All outputs return to their reset values at the next edge.
- Read-after-write to the same word in back-to-back requests returns the new data.

## Configuration
- Macro `DMEM_ALIGN_CHECK_EN`.
- Defined: before the access, `be` must match `addr[1:0]`:
  - one-hot `0001<<addr[1:0]`;
  - or `0011<<addr[1:0]` with `addr[0]`=0;
  - or `1111` with `addr[1:0]`=00;
  - or 0000.
  - Any other combination gives `rsp_err`=1, no write, `rsp_rdata`=0.
  - For loads the check uses `be`.
- Not defined: `addr[1:0]` and the `be` pattern are not checked. Every in-range access proceeds, with lanes written exactly per `be`.

## Test plan
- Reset then word store: reset 2 cycles, then store addr 0x10, wdata 0xDEADBEEF, be 1111 (`WAIT_STATES`=1).
  - `rsp_valid` is exactly 1 cycle after acceptance, `err`=0.
  - A load from 0x10 returns 0xDEADBEEF.
- Byte-lane merge:
  - Store 0x11223344 to 0x20 with be 1111.
  - Store 0x0000AA00 with be 0010.
  - Load 0x20 returns 0x1122AA44.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_rdata` and `err` are stable throughout and `req_ready`=0.
  - The response is accepted on the first `rsp_ready`, and `req_ready`=1 the next cycle.
- Out of range with `DEPTH_WORDS`=1024:
  - Store to 0x1000 gives `err`=1 and `rdata`=0.
  - A load from 0x0000 shows it was unchanged.
- Reset during WAIT with `WAIT_STATES`=4:
  - Accept a store to 0x30, assert `reset` 2 cycles later.
  - No `rsp_valid` is produced.
  - A subsequent load from 0x30 returns the old value.
- Alignment: store addr 0x41, be 0011.
  - With `DMEM_ALIGN_CHECK_EN` defined: `err`=1, no write.
  - Without it: `err`=0, lanes 0–1 written.
